// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle logic/arith/shift ops, an iterative
// shift-add multiply, and a {Z,V,N} flag register updated under a per-op write mask.
module alu_seq #(
   parameter int unsigned WIDTH  = 16,
   parameter bit          SAT_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] ALU_in1,
   input  logic [WIDTH-1:0] ALU_in2,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALU_out,
   output logic [2:0]       flag,
   output logic [2:0]       flag_write
);

   localparam int unsigned ShW = $clog2(WIDTH);

   localparam logic [2:0] OpAdd = 3'b000;
   localparam logic [2:0] OpSub = 3'b001;
   localparam logic [2:0] OpAnd = 3'b010;
   localparam logic [2:0] OpXor = 3'b011;
   localparam logic [2:0] OpSll = 3'b100;
   localparam logic [2:0] OpSra = 3'b101;
   localparam logic [2:0] OpRor = 3'b110;
   localparam logic [2:0] OpMul = 3'b111;

   localparam logic [WIDTH-1:0] SatPos = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SatNeg = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic {StIdle, StMulRun} state_e;

   state_e           state_q, state_d;
   logic [ShW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, acc_q, acc_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             valid_q, valid_d;
   logic [2:0]       fw_q, fw_d, flag_q, flag_d;

   logic [ShW-1:0]     sh;
   logic [WIDTH-1:0]   add_res, sub_res, alu_res, mul_term, mul_res;
   logic [2*WIDTH-1:0] rot2;
   logic               add_ovf, sub_ovf, alu_v;
   logic [2:0]         alu_fw, alu_flags;
   logic               accept;

   // Single-cycle datapath; MUL result comes from the iterative path below.
   always_comb begin
      sh      = ALU_in2[ShW-1:0];
      add_res = ALU_in1 + ALU_in2;
      sub_res = ALU_in1 - ALU_in2;
      add_ovf = (ALU_in1[WIDTH-1] == ALU_in2[WIDTH-1]) && (add_res[WIDTH-1] != ALU_in1[WIDTH-1]);
      sub_ovf = (ALU_in1[WIDTH-1] != ALU_in2[WIDTH-1]) && (sub_res[WIDTH-1] != ALU_in1[WIDTH-1]);
      rot2    = {ALU_in1, ALU_in1} >> sh;
      alu_res = '0;
      alu_v   = 1'b0;
      alu_fw  = 3'b100;
      unique case (op)
         OpAdd: begin
            alu_v   = add_ovf;
            alu_fw  = 3'b111;
            alu_res = (SAT_EN && add_ovf) ? (ALU_in1[WIDTH-1] ? SatNeg : SatPos) : add_res;
         end
         OpSub: begin
            alu_v   = sub_ovf;
            alu_fw  = 3'b111;
            alu_res = (SAT_EN && sub_ovf) ? (ALU_in1[WIDTH-1] ? SatNeg : SatPos) : sub_res;
         end
         OpAnd:   alu_res = ALU_in1 & ALU_in2;
         OpXor:   alu_res = ALU_in1 ^ ALU_in2;
         OpSll:   alu_res = ALU_in1 << sh;
         OpSra:   alu_res = $unsigned($signed(ALU_in1) >>> sh);
         OpRor:   alu_res = rot2[WIDTH-1:0];
         default: alu_res = '0;
      endcase
      alu_flags = {(alu_res == '0), alu_v, alu_res[WIDTH-1]};
   end

   assign mul_term = mul_b_q[cnt_q] ? (mul_a_q << cnt_q) : '0;
   assign mul_res  = acc_q + mul_term;

   assign in_ready = (state_q == StIdle) && (!valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
      acc_d   = acc_q;
      out_d   = out_q;
      fw_d    = fw_q;
      flag_d  = flag_q;
      valid_d = valid_q && !out_ready;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (op == OpMul) begin
                  state_d = StMulRun;
                  mul_a_d = ALU_in1;
                  mul_b_d = ALU_in2;
                  acc_d   = '0;
                  cnt_d   = '0;
               end else begin
                  out_d   = alu_res;
                  fw_d    = alu_fw;
                  flag_d  = (flag_q & ~alu_fw) | (alu_flags & alu_fw);
                  valid_d = 1'b1;
               end
            end
         end
         StMulRun: begin
            acc_d = mul_res;
            cnt_d = cnt_q + ShW'(1);
            if (cnt_q == ShW'(WIDTH - 1)) begin
               out_d   = mul_res;
               fw_d    = 3'b100;
               flag_d  = {(mul_res == '0), flag_q[1:0]};
               valid_d = 1'b1;
               state_d = StIdle;
               cnt_d   = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         mul_a_q <= '0;
         mul_b_q <= '0;
         acc_q   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         fw_q    <= '0;
         flag_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mul_a_q <= mul_a_d;
         mul_b_q <= mul_b_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         fw_q    <= fw_d;
         flag_q  <= flag_d;
      end
   end

   assign out_valid  = valid_q;
   assign ALU_out    = out_q;
   assign flag       = flag_q;
   assign flag_write = fw_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: one saturating and one wrapping instance share stimulus;
// a vector table covers single-cycle ops, hand sequences cover MUL, backpressure, reset.
module tb_alu_seq;

   localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_XOR = 3'b011;
   localparam logic [2:0] OP_SLL = 3'b100, OP_SRA = 3'b101, OP_ROR = 3'b110, OP_MUL = 3'b111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [15:0] a = '0, b = '0;
   logic [2:0]  op = '0;

   logic        rdy_s, rdy_w, ov_s, ov_w;
   logic [15:0] out_s, out_w;
   logic [2:0]  flag_s, flag_w, fw_s, fw_w;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(16), .SAT_EN(1'b1)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .ALU_in1(a), .ALU_in2(b),
      .op(op), .out_valid(ov_s), .out_ready(out_ready), .ALU_out(out_s), .flag(flag_s),
      .flag_write(fw_s)
   );

   alu_seq #(.WIDTH(16), .SAT_EN(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w), .ALU_in1(a), .ALU_in2(b),
      .op(op), .out_valid(ov_w), .out_ready(out_ready), .ALU_out(out_w), .flag(flag_w),
      .flag_write(fw_w)
   );

   typedef struct {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] out_s;
      logic [15:0] out_w;
      logic [2:0]  flag_s;
      logic [2:0]  flag_w;
      logic [2:0]  fw;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one request and return #1 after its accept edge.
   task automatic issue(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
      op       = o;
      a        = x;
      b        = y;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic chk_both(input string name, input logic [15:0] es, input logic [15:0] ew,
                           input logic [2:0] fs, input logic [2:0] fwr, input logic [2:0] mask);
      chk({name, " valid_s"}, ov_s, 1);
      chk({name, " valid_w"}, ov_w, 1);
      chk({name, " out_s"}, out_s, es);
      chk({name, " out_w"}, out_w, ew);
      chk({name, " flag_s"}, flag_s, fs);
      chk({name, " flag_w"}, flag_w, fwr);
      chk({name, " fw_s"}, fw_s, mask);
      chk({name, " fw_w"}, fw_w, mask);
   endtask

   initial begin
      //          op      a         b         out_s     out_w     fl_s    fl_w    fw
      vecs[0]  = '{OP_ADD, 16'h8FFF, 16'h8FFF, 16'h8000, 16'h1FFE, 3'b011, 3'b010, 3'b111};
      vecs[1]  = '{OP_XOR, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 3'b111, 3'b110, 3'b100};
      vecs[2]  = '{OP_SUB, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 3'b100, 3'b100, 3'b111};
      vecs[3]  = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h7FFF, 16'h8000, 3'b010, 3'b011, 3'b111};
      vecs[4]  = '{OP_SUB, 16'h8000, 16'h0001, 16'h8000, 16'h7FFF, 3'b011, 3'b010, 3'b111};
      vecs[5]  = '{OP_AND, 16'hF0F0, 16'h0F0F, 16'h0000, 16'h0000, 3'b111, 3'b110, 3'b100};
      vecs[6]  = '{OP_SLL, 16'h0001, 16'h0004, 16'h0010, 16'h0010, 3'b011, 3'b010, 3'b100};
      vecs[7]  = '{OP_SLL, 16'h00FF, 16'hFFF0, 16'h00FF, 16'h00FF, 3'b011, 3'b010, 3'b100};
      vecs[8]  = '{OP_SRA, 16'h8000, 16'h0003, 16'hF000, 16'hF000, 3'b011, 3'b010, 3'b100};
      vecs[9]  = '{OP_SRA, 16'h4000, 16'h0010, 16'h4000, 16'h4000, 3'b011, 3'b010, 3'b100};
      vecs[10] = '{OP_ROR, 16'h0001, 16'h0001, 16'h8000, 16'h8000, 3'b011, 3'b010, 3'b100};
      vecs[11] = '{OP_ROR, 16'h1234, 16'h0004, 16'h4123, 16'h4123, 3'b011, 3'b010, 3'b100};
      vecs[12] = '{OP_ADD, 16'h1234, 16'h1111, 16'h2345, 16'h2345, 3'b000, 3'b000, 3'b111};
      vecs[13] = '{OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 16'hFFFE, 3'b001, 3'b001, 3'b111};
      vecs[14] = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 3'b100, 3'b100, 3'b111};
      vecs[15] = '{OP_ADD, 16'h7000, 16'h7000, 16'h7FFF, 16'hE000, 3'b010, 3'b011, 3'b111};

      // Reset state
      #2;
      chk("rst valid", {ov_s, ov_w}, 0);
      chk("rst out", {out_s, out_w}, 0);
      chk("rst flag", {flag_s, flag_w}, 0);
      chk("rst fw", {fw_s, fw_w}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("ready after rst", {rdy_s, rdy_w}, 2'b11);

      // Back-to-back single-cycle ops, consumed every cycle
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("v%0d ready", i), {rdy_s, rdy_w}, 2'b11);
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         chk_both($sformatf("v%0d", i), vecs[i].out_s, vecs[i].out_w, vecs[i].flag_s,
                  vecs[i].flag_w, vecs[i].fw);
      end

      // MUL: 16-cycle latency, in_ready low while running
      issue(OP_MUL, 16'h0003, 16'h0005);
      for (int k = 1; k < 16; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("mul1 c%0d valid", k), {ov_s, ov_w}, 0);
         chk($sformatf("mul1 c%0d ready", k), {rdy_s, rdy_w}, 0);
      end
      @(posedge clk);
      #1;
      chk_both("mul1", 16'h000F, 16'h000F, 3'b010, 3'b011, 3'b100);
      issue(OP_MUL, 16'h1000, 16'h0010);
      repeat (15) @(posedge clk);
      #1;
      chk("mul2 early valid", {ov_s, ov_w}, 0);
      @(posedge clk);
      #1;
      chk_both("mul2", 16'h0000, 16'h0000, 3'b110, 3'b111, 3'b100);

      // Drain, then hold a ROR result under backpressure
      @(posedge clk);
      #1;
      chk("drain valid", {ov_s, ov_w}, 0);
      out_ready = 1'b0;
      issue(OP_ROR, 16'h0001, 16'h0001);
      for (int k = 0; k < 3; k++) begin
         chk_both($sformatf("bp%0d", k), 16'h8000, 16'h8000, 3'b010, 3'b011, 3'b100);
         chk($sformatf("bp%0d ready", k), {rdy_s, rdy_w}, 0);
         @(posedge clk);
         #1;
      end
      chk_both("bp3", 16'h8000, 16'h8000, 3'b010, 3'b011, 3'b100);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         issue(OP_SLL, 16'h0001, 16'(k + 1));
         chk_both($sformatf("sll%0d", k), 16'h0001 << (k + 1), 16'h0001 << (k + 1),
                  3'b010, 3'b011, 3'b100);
         chk($sformatf("sll%0d ready", k), {rdy_s, rdy_w}, 2'b11);
      end

      // Reset asserted partway through a MUL
      issue(OP_MUL, 16'h0003, 16'h0005);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort valid", {ov_s, ov_w}, 0);
      chk("abort flag", {flag_s, flag_w}, 0);
      chk("abort out", {out_s, out_w}, 0);
      chk("abort fw", {fw_s, fw_w}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post-abort ready", {rdy_s, rdy_w}, 2'b11);
      chk("post-abort valid", {ov_s, ov_w}, 0);
      issue(OP_ADD, 16'h0001, 16'h0001);
      chk_both("add after abort", 16'h0002, 16'h0002, 3'b000, 3'b000, 3'b111);
      @(posedge clk);
      #1;
      chk("final drain", {ov_s, ov_w}, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
